// File: rtl/s_pea_out_collector.sv
// Output collector for the bottom PE row: packs one result per enabled lane into a row word,
// buffers rows in a small FIFO and streams them out with a last flag over a valid/ready port.
module s_pea_out_collector #(
    parameter int N_BITS  = 32,
    parameter int N_LANES = 4,
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    input  logic [LEN_W-1:0]          cfg_len_i,
    input  logic [N_LANES-1:0]        lane_en_i,
    input  logic [N_LANES*N_BITS-1:0] pe_res_i,
    input  logic [N_LANES-1:0]        pe_valid_i,
    output logic                      pea_ready_o,
    output logic [N_LANES*N_BITS-1:0] m_data_o,
    output logic                      m_valid_o,
    output logic                      m_last_o,
    input  logic                      m_ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [LEN_W-1:0]          beats_o
);

    localparam int ROW_W = N_LANES * N_BITS;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX_C = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic [N_LANES-1:0] mask_q, mask_d;
    logic [ROW_W-1:0]   mem_q [DEPTH];
    logic [ROW_W-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0]   last_q, last_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               is_last_s;
    logic [ROW_W-1:0]   row_s;

    // Ready depends only on registered state and count, so a full FIFO blocks pushes even on a pop.
    assign pea_ready_o = (state_q == ST_RUN) && (count_q < DEPTH_C);
    assign accept_s    = pea_ready_o && ((pe_valid_i & mask_q) == mask_q);
    assign push_s      = accept_s;
    assign pop_s       = m_valid_o && m_ready_i;
    assign is_last_s   = (beats_q == (len_q - LEN_W'(1)));

    assign m_valid_o = (count_q != {CNT_W{1'b0}});
    assign m_data_o  = m_valid_o ? mem_q[rd_ptr_q] : {ROW_W{1'b0}};
    assign m_last_o  = m_valid_o ? last_q[rd_ptr_q] : 1'b0;
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_DONE);
    assign beats_o   = beats_q;

    // Row packing: disabled lanes are forced to zero.
    always_comb begin
        row_s = {ROW_W{1'b0}};
        for (int i = 0; i < N_LANES; i++) begin
            if (mask_q[i]) begin
                row_s[i*N_BITS +: N_BITS] = pe_res_i[i*N_BITS +: N_BITS];
            end else begin
                row_s[i*N_BITS +: N_BITS] = {N_BITS{1'b0}};
            end
        end
    end

    // Transfer sequencing: next state, latched configuration and beat counter.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mask_d  = mask_q;
        beats_d = beats_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d   = cfg_len_i;
                    mask_d  = lane_en_i;
                    beats_d = {LEN_W{1'b0}};
                    if ((cfg_len_i == {LEN_W{1'b0}}) || (lane_en_i == {N_LANES{1'b0}})) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    beats_d = beats_q + LEN_W'(1);
                    if (is_last_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // The last-tagged word is always the sole entry by the time it reaches the head.
                if (pop_s && (count_q == CNT_W'(1))) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO next-state: storage write, pointer wrap and occupancy.
    always_comb begin
        mem_d    = mem_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q]  = row_s;
            last_d[wr_ptr_q] = is_last_s;
            wr_ptr_d = (wr_ptr_q == PTR_MAX_C) ? {PTR_W{1'b0}} : (wr_ptr_q + PTR_W'(1));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX_C) ? {PTR_W{1'b0}} : (rd_ptr_q + PTR_W'(1));
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; asynchronous reset discards FIFO contents.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            len_q    <= {LEN_W{1'b0}};
            mask_q   <= {N_LANES{1'b0}};
            beats_q  <= {LEN_W{1'b0}};
            last_q   <= {DEPTH{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ROW_W{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            mask_q   <= mask_d;
            beats_q  <= beats_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_s_pea_out_collector.sv
// Randomized bench for s_pea_out_collector against a queue-based transfer model.
module tb_s_pea_out_collector;

    localparam int N_BITS  = 32;
    localparam int N_LANES = 4;
    localparam int DEPTH   = 4;
    localparam int LEN_W   = 16;
    localparam int ROW_W   = N_BITS * N_LANES;

    logic               clk_i = 1'b0;
    logic               rst_n_i = 1'b0;
    logic               start_i = 1'b0;
    logic [LEN_W-1:0]   cfg_len_i = '0;
    logic [N_LANES-1:0] lane_en_i = '0;
    logic [ROW_W-1:0]   pe_res_i = '0;
    logic [N_LANES-1:0] pe_valid_i = '0;
    logic               pea_ready_o;
    logic [ROW_W-1:0]   m_data_o;
    logic               m_valid_o;
    logic               m_last_o;
    logic               m_ready_i = 1'b0;
    logic               busy_o;
    logic               done_o;
    logic [LEN_W-1:0]   beats_o;

    s_pea_out_collector #(
        .N_BITS(N_BITS), .N_LANES(N_LANES), .DEPTH(DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .cfg_len_i(cfg_len_i),
        .lane_en_i(lane_en_i), .pe_res_i(pe_res_i), .pe_valid_i(pe_valid_i),
        .pea_ready_o(pea_ready_o), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
        .m_last_o(m_last_o), .m_ready_i(m_ready_i), .busy_o(busy_o), .done_o(done_o),
        .beats_o(beats_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 done pulse.
    int               ph = 0;
    logic [ROW_W-1:0] q_d[$];
    bit               q_l[$];
    int               m_len = 0;
    logic [3:0]       m_mask = '0;
    int               m_beats = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = 0;
        q_d.delete();
        q_l.delete();
        m_len = 0;
        m_mask = '0;
        m_beats = 0;
    endtask

    // One clock: compare outputs at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        bit               pop, acc;
        logic [ROW_W-1:0] w;
        int               sz;
        @(negedge clk_i);
        sz = q_d.size();
        check("m_valid",   128'(m_valid_o),   128'(sz != 0));
        check("m_data",    128'(m_data_o),    (sz != 0) ? q_d[0] : 128'h0);
        check("m_last",    128'(m_last_o),    128'((sz != 0) ? q_l[0] : 1'b0));
        check("pea_ready", 128'(pea_ready_o), 128'((ph == 1) && (sz < DEPTH)));
        check("busy",      128'(busy_o),      128'(ph != 0));
        check("done",      128'(done_o),      128'(ph == 3));
        check("beats",     128'(beats_o),     128'(m_beats));

        pop = (sz != 0) && m_ready_i;
        acc = (ph == 1) && (sz < DEPTH) && ((pe_valid_i & m_mask) == m_mask);
        w = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (m_mask[i]) w[i*N_BITS +: N_BITS] = pe_res_i[i*N_BITS +: N_BITS];
        end
        case (ph)
            0: if (start_i) begin
                m_len   = int'(cfg_len_i);
                m_mask  = lane_en_i;
                m_beats = 0;
                ph = ((m_len == 0) || (m_mask == 4'd0)) ? 3 : 1;
            end
            2: if (pop && q_l[0]) ph = 3;
            3: ph = 0;
            default: ;
        endcase
        if (pop) begin
            void'(q_d.pop_front());
            void'(q_l.pop_front());
        end
        if (acc) begin
            m_beats++;
            q_d.push_back(w);
            q_l.push_back(m_beats == m_len);
            if (m_beats == m_len) ph = 2;
        end
        @(posedge clk_i);
        #1;
    endtask

    // vmode: 0 all valid, 1 random, 2 partial-mask pattern, 3 lane-3 skew; rmode: 0 ready, 1 random, 2 held low until hold.
    task automatic drive(input int vmode, input int rmode, input int n, input int hold);
        for (int i = 0; i < N_LANES; i++) pe_res_i[i*N_BITS +: N_BITS] = $urandom();
        case (vmode)
            0: pe_valid_i = 4'hF;
            1: for (int i = 0; i < N_LANES; i++) pe_valid_i[i] = ($urandom_range(0, 3) != 0);
            2: begin
                pe_valid_i = 4'b1101;
                pe_res_i[0*N_BITS +: N_BITS] = 32'h0000_000A;
                pe_res_i[2*N_BITS +: N_BITS] = 32'h0000_000B;
            end
            3: pe_valid_i = (n < 3) ? 4'b0111 : 4'b1111;
            default: pe_valid_i = 4'hF;
        endcase
        case (rmode)
            0: m_ready_i = 1'b1;
            1: m_ready_i = 1'($urandom_range(0, 1));
            2: m_ready_i = (n >= hold);
            default: m_ready_i = 1'b1;
        endcase
    endtask

    task automatic finish_xfer(input int vmode, input int rmode, input int hold,
                               input int restart_n, input int first_n);
        int n = first_n;
        while ((ph != 0) && (n < 3000)) begin
            drive(vmode, rmode, n, hold);
            if (n == restart_n) begin
                start_i = 1'b1;
                cfg_len_i = 16'd2;
                lane_en_i = 4'b0001;
            end else begin
                start_i = 1'b0;
            end
            cycle();
            n++;
        end
        start_i = 1'b0;
        check("xfer_bound", 128'(ph == 0), 128'(1));
    endtask

    task automatic transfer(input int len, input logic [3:0] mask, input int vmode,
                            input int rmode, input int hold, input int restart_n);
        drive(vmode, rmode, 0, hold);
        start_i = 1'b1;
        cfg_len_i = 16'(len);
        lane_en_i = mask;
        cycle();
        start_i = 1'b0;
        finish_xfer(vmode, rmode, hold, restart_n, 1);
    endtask

    task automatic mid_reset();
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_m_valid",   128'(m_valid_o),   128'(0));
        check("rst_m_data",    128'(m_data_o),    128'(0));
        check("rst_pea_ready", 128'(pea_ready_o), 128'(0));
        check("rst_busy",      128'(busy_o),      128'(0));
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n;
        model_reset();
        #12;
        check("por_m_valid", 128'(m_valid_o), 128'(0));
        check("por_beats",   128'(beats_o),   128'(0));
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        cycle();

        // Basic stream
        transfer(3, 4'hF, 0, 0, 0, -1);
        check("basic_beats", 128'(beats_o), 128'(3));

        // Partial mask with lane 1 invalid
        drive(2, 0, 0, 0);
        start_i = 1'b1; cfg_len_i = 16'd1; lane_en_i = 4'b0101;
        cycle();
        start_i = 1'b0;
        drive(2, 0, 1, 0);
        cycle();
        check("partial_word", m_data_o, 128'h00000000_0000000B_00000000_0000000A);
        finish_xfer(2, 0, 0, -1, 2);

        // Backpressure: downstream stalled well past FIFO capacity
        transfer(8, 4'hF, 0, 2, 12, -1);
        check("bp_beats", 128'(beats_o), 128'(8));

        // Lane 3 valid arrives late
        transfer(1, 4'hF, 3, 0, 0, -1);

        // Degenerate starts and a start while running
        transfer(0, 4'hF, 0, 0, 0, -1);
        transfer(3, 4'h0, 0, 0, 0, -1);
        transfer(4, 4'hF, 0, 2, 6, 2);
        check("restart_beats", 128'(beats_o), 128'(4));

        // Reset with two words buffered
        drive(0, 2, 0, 1000);
        start_i = 1'b1; cfg_len_i = 16'd8; lane_en_i = 4'hF;
        cycle();
        start_i = 1'b0;
        n = 1;
        while ((q_d.size() < 2) && (n < 50)) begin
            drive(0, 2, n, 1000);
            cycle();
            n++;
        end
        check("pre_rst_words", 128'(m_valid_o), 128'(1));
        mid_reset();
        cycle();
        transfer(5, 4'hF, 1, 1, 0, -1);
        check("post_rst_beats", 128'(beats_o), 128'(5));

        // Random transfers
        for (int k = 0; k < 25; k++) begin
            transfer($urandom_range(1, 12), 4'($urandom_range(0, 15)), 1, 1, 0, -1);
            if ($urandom_range(0, 3) == 0) cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
